aes_key_sched: RTL

//  Iterative AES-128 key expansion feeding the add-round-key stage that follows mix_cols.

---
 rtl/aes_key_sched_pkg.sv | 45 ++++
 rtl/aes_key_sched_if.sv | 23 ++
 rtl/aes_key_sched_sub_word.sv | 12 +
 rtl/aes_key_sched.sv | 107 ++++++++++
 4 files changed

// File: rtl/aes_key_sched_pkg.sv
// Shared AES constants and byte-level helpers (S-box, xtime) for the round datapath.
// The S-box table is also used by sub_bytes.
package aes_key_sched_pkg;

    localparam int unsigned AES_NR        = 10;
    localparam logic [7:0]  AES_RCON_INIT = 8'h01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_e;

    // Entry 0 sits in the top byte so the table reads in the usual row order.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Round-key stream between the key scheduler and the add-round-key stage.
interface aes_key_sched_if;

    logic [127:0] key_in;
    logic         key_load;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;

    modport master (
        output key_in, key_load, rk_ready,
        input  rk_valid, rk_out, rk_idx, busy, done
    );

    modport slave (
        input  key_in, key_load, rk_ready,
        output rk_valid, rk_out, rk_idx, busy, done
    );

endinterface

// File: rtl/aes_key_sched_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
    import aes_key_sched_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion: emits round keys 0..NUM_ROUNDS over a valid/ready stream.
// Only NUM_ROUNDS = 10 is meaningful; the index counter is sized for it.
module aes_key_sched
    import aes_key_sched_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES_NR,
    parameter logic [7:0]  RCON_INIT  = AES_RCON_INIT
)
(
    input  logic            clk,
    input  logic            rst,
    aes_key_sched_if.slave  bus
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_e    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;

    logic [31:0]  w0_s, w1_s, w2_s, w3_s;
    logic [31:0]  sub_s, t_s;
    logic [31:0]  nw0_s, nw1_s, nw2_s, nw3_s;
    logic         accept_s;

    assign w0_s = key_q[127:96];
    assign w1_s = key_q[95:64];
    assign w2_s = key_q[63:32];
    assign w3_s = key_q[31:0];

    aes_sub_word u_sub_word (
        .word_i (rot_word(w3_s)),
        .word_o (sub_s)
    );

    assign t_s   = sub_s ^ {rcon_q, 24'h000000};
    assign nw0_s = w0_s ^ t_s;
    assign nw1_s = w1_s ^ nw0_s;
    assign nw2_s = w2_s ^ nw1_s;
    assign nw3_s = w3_s ^ nw2_s;

    assign accept_s = (state_q == ST_RUN) && bus.rk_ready;

    // Next-state: a fresh key_load always wins over an accept in the same cycle.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rcon_d  = rcon_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        if (bus.key_load) begin
            state_d = ST_RUN;
            key_d   = bus.key_in;
            idx_d   = 4'd0;
            rcon_d  = RCON_INIT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (accept_s) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            key_d  = {nw0_s, nw1_s, nw2_s, nw3_s};
                            idx_d  = idx_q + 4'd1;
                            rcon_d = xtime(rcon_q);
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, key, rcon and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= 128'h0;
            rcon_q  <= RCON_INIT;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rcon_q  <= rcon_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign bus.rk_valid = (state_q == ST_RUN);
    assign bus.busy     = (state_q == ST_RUN);
    assign bus.rk_out   = key_q;
    assign bus.rk_idx   = idx_q;
    assign bus.done     = done_q;

endmodule
